// File: rtl/sn_sched_pkg.sv
// sn_sched_pkg: shared state encoding, operand bundle type and default sizing
// for the stochastic-number generator scheduler.
package sn_sched_pkg;

    localparam int SN_NUM_REQ_DEF    = 4;
    localparam int SN_STREAM_LEN_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_GEN,
        ST_RUN,
        ST_DONE,
        ST_STOP
    } sn_state_t;

    // Four 4-bit binary operands handed to the generator as one bundle.
    typedef logic [3:0][3:0] sn_opnd_t;

endpackage

// File: rtl/sn_rr_arbiter.sv
// sn_rr_arbiter: combinational rotate-priority select; picks the first
// requesting index at or after rr_ptr_i, wrapping from NUM_REQ-1 to 0.
module sn_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      index_o,
    output logic               any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        index_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                index_o       = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sn_gen_sched.sv
// sn_gen_sched: round-robin scheduler sharing one stochastic-number generator among NUM_REQ requesters.
// Define SN_SCHED_ABORT_EN to let the owner abort a stream through the STOP state.
module sn_gen_sched
    import sn_sched_pkg::*;
#(
    parameter int NUM_REQ    = SN_NUM_REQ_DEF,
    parameter int STREAM_LEN = SN_STREAM_LEN_DEF
) (
    input  logic                   i_clk_sn_sched,
    input  logic                   i_rst_n_sn_sched,
    input  logic [NUM_REQ-1:0]     i_req,
    input  sn_opnd_t [NUM_REQ-1:0] i_x_bn,
    input  logic [NUM_REQ-1:0]     i_abort,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [NUM_REQ-1:0]     o_done,
    output logic                   o_gen_start,
    output logic                   o_gen_stop,
    output sn_opnd_t               o_gen_x_bn,
    input  logic                   i_gen_isgen,
    output logic                   o_busy,
    output logic                   o_short
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(2 * STREAM_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(2 * STREAM_LEN);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(STREAM_LEN);

    sn_state_t          state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    sn_opnd_t           x_q, x_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               short_q, short_d;
    logic               abort_own, release_own;
    logic [IW-1:0]      owner_inc;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    sn_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req_i    (i_req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (arb_grant),
        .index_o  (arb_idx),
        .any_o    (arb_any)
    );

    assign owner_inc = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

`ifdef SN_SCHED_ABORT_EN
    logic stop_sent_q, stop_sent_d;
    assign abort_own  = |(i_abort & grant_q);
    assign o_gen_stop = (state_q == ST_STOP) && !stop_sent_q;
`else
    logic unused_abort;
    assign unused_abort = ^i_abort;
    assign abort_own    = 1'b0;
    assign o_gen_stop   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        short_d     = short_q;
        release_own = 1'b0;
`ifdef SN_SCHED_ABORT_EN
        stop_sent_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    owner_d = arb_idx;
                    x_d     = i_x_bn[arb_idx];
                    cnt_d   = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT_GEN;
            ST_WAIT_GEN: begin
                if (abort_own) begin
                    state_d = ST_STOP;
                end else if (i_gen_isgen) begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_own) begin
                    state_d = ST_STOP;
                end else if (i_gen_isgen) begin
                    if (cnt_q < CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    if (cnt_q < CNT_MIN) short_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: release_own = 1'b1;
            ST_STOP: begin
`ifdef SN_SCHED_ABORT_EN
                // Stop pulse goes out on the first STOP cycle; drain waits for the generator to go idle.
                stop_sent_d = 1'b1;
                if (stop_sent_q && !i_gen_isgen) release_own = 1'b1;
`else
                release_own = 1'b1;
`endif
            end
            default: release_own = 1'b1;
        endcase
        if (release_own) begin
            grant_d  = '0;
            rr_ptr_d = owner_inc;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk_sn_sched or negedge i_rst_n_sn_sched) begin
        if (!i_rst_n_sn_sched) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            x_q      <= '0;
            cnt_q    <= '0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
        end
    end

`ifdef SN_SCHED_ABORT_EN
    always_ff @(posedge i_clk_sn_sched or negedge i_rst_n_sn_sched) begin
        if (!i_rst_n_sn_sched) stop_sent_q <= 1'b0;
        else                   stop_sent_q <= stop_sent_d;
    end
`endif

    assign o_grant     = grant_q;
    assign o_done      = (state_q == ST_DONE) ? grant_q : '0;
    assign o_gen_start = (state_q == ST_LAUNCH);
    assign o_gen_x_bn  = x_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_short     = short_q;

endmodule

// File: tb/tb_sn_gen_sched.sv
// tb_sn_gen_sched: randomized scoreboard bench for sn_gen_sched with a
// behavioural generator model and a round-robin reference model.
module tb_sn_gen_sched;
    import sn_sched_pkg::*;

    localparam int N  = 4;
    localparam int SL = 16;
`ifdef SN_SCHED_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     i_req, i_abort, o_grant, o_done;
    sn_opnd_t [N-1:0] i_x_bn;
    logic             o_gen_start, o_gen_stop, o_busy, o_short;
    logic             i_gen_isgen = 1'b0;
    sn_opnd_t         o_gen_x_bn;

    always #5 clk = ~clk;

    sn_gen_sched #(.NUM_REQ(N), .STREAM_LEN(SL)) dut (
        .i_clk_sn_sched   (clk),
        .i_rst_n_sn_sched (rst_n),
        .i_req            (i_req),
        .i_x_bn           (i_x_bn),
        .i_abort          (i_abort),
        .o_grant          (o_grant),
        .o_done           (o_done),
        .o_gen_start      (o_gen_start),
        .o_gen_stop       (o_gen_stop),
        .o_gen_x_bn       (o_gen_x_bn),
        .i_gen_isgen      (i_gen_isgen),
        .o_busy           (o_busy),
        .o_short          (o_short)
    );

    typedef struct {
        int          owner;
        logic [15:0] x;
        int          ndone;
        int          nstop;
        logic        short_after;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    endtask

    // Reference arbitration rule: first requester at or after ptr, wrapping.
    function automatic int rr_owner(input logic [N-1:0] vec, input int ptr);
        int idx;
        for (int d = 0; d < N; d++) begin
            idx = (ptr + d) % N;
            if (vec[idx]) return idx;
        end
        return -1;
    endfunction

    // Generator model: after o_gen_start, idle cfg_delay cycles, then isgen high cfg_beats cycles.
    int cfg_delay = 0, cfg_beats = 0, gen_wait = 0, gen_left = 0, gen_hi = 0;
    bit gen_active = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gen_active  = 0;
                i_gen_isgen = 1'b0;
            end else if (gen_active) begin
                if (o_gen_stop) begin
                    gen_active  = 0;
                    i_gen_isgen = 1'b0;
                end else if (gen_wait > 0) begin
                    gen_wait--;
                end else if (gen_left > 0) begin
                    i_gen_isgen = 1'b1;
                    gen_left--;
                    gen_hi++;
                end else begin
                    i_gen_isgen = 1'b0;
                    gen_active  = 0;
                end
            end else if (o_gen_start) begin
                gen_active = 1;
                gen_wait   = cfg_delay;
                gen_left   = cfg_beats;
            end
        end
    end

    // Monitor: pops an expectation at each launch, checks it through to the end of the stream.
    exp_t cur;
    bit   have = 0, busy_prev = 0;
    int   done_seen = 0, stop_seen = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (o_gen_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 64'd1, 64'd0);
                end else begin
                    cur       = exp_q.pop_front();
                    have      = 1;
                    done_seen = 0;
                    stop_seen = 0;
                    chk("grant_at_launch", o_grant, 64'd1 << cur.owner);
                    chk("x_at_launch", o_gen_x_bn, cur.x);
                end
            end
            if (o_gen_stop === 1'b1) stop_seen++;
            if (o_done !== '0 && rst_n === 1'b1) begin
                done_seen++;
                if (!have) begin
                    chk("unexpected_done", o_done, 64'd0);
                end else begin
                    chk("done_owner", o_done, 64'd1 << cur.owner);
                    chk("x_held_at_done", o_gen_x_bn, cur.x);
                end
            end
            if (busy_prev && o_busy === 1'b0 && have) begin
                chk("done_count", done_seen, cur.ndone);
                chk("stop_count", stop_seen, cur.nstop);
                chk("short_flag", o_short, cur.short_after);
                chk("grant_released", o_grant, 64'd0);
                have = 0;
            end
            busy_prev = (o_busy === 1'b1);
        end
    end

    int   model_ptr   = 0;
    logic model_short = 1'b0;

    // scr: 0 keep operands, 1 randomize all, 2 zero the owner's operands during the stream.
    task automatic run_txn(input logic [N-1:0] vec, input int beats, input int delay, input int scr,
                           input int rst_at, input int abort_at, input bit force_x, input logic [15:0] xval);
        exp_t e;
        int   own, guard, base;
        bit   fired;
        for (int j = 0; j < N; j++) i_x_bn[j] = 16'($urandom);
        own = rr_owner(vec, model_ptr);
        if (force_x) i_x_bn[own] = xval;
        e.owner = own;
        e.x     = i_x_bn[own];
        if (rst_at > 0) begin
            e.ndone = 0; e.nstop = 0; e.short_after = 1'b0;
        end else if (abort_at > 0 && ABORT_ON) begin
            e.ndone = 0; e.nstop = 1; e.short_after = model_short;
        end else begin
            model_short   = model_short | (beats < SL);
            e.ndone = 1; e.nstop = 0; e.short_after = model_short;
        end
        cfg_beats = beats;
        cfg_delay = delay;
        base      = gen_hi;
        exp_q.push_back(e);
        i_req = vec;

        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (o_busy !== 1'b1 && guard < 10);
        chk("busy_rise", o_busy, 64'd1);

        fired = 0;
        guard = 0;
        while (o_busy === 1'b1 && guard < 400) begin
            if (scr == 1) for (int j = 0; j < N; j++) i_x_bn[j] = 16'($urandom);
            if (scr == 2) i_x_bn[own] = 16'h0000;
            if (!fired && rst_at > 0 && (gen_hi - base) >= rst_at) begin
                fired = 1;
                rst_n = 1'b0;
                #1;
                chk("reset_outputs_zero",
                    {o_grant, o_done, o_gen_start, o_gen_stop, o_gen_x_bn, o_busy, o_short}, 64'd0);
            end
            if (!fired && abort_at > 0 && (gen_hi - base) >= abort_at) begin
                fired = 1;
                i_abort[own] = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        chk("busy_fall", o_busy, 64'd0);
        i_abort = '0;
        i_req   = '0;
        if (rst_at > 0) begin
            @(negedge clk);
            rst_n       = 1'b1;
            model_ptr   = 0;
            model_short = 1'b0;
        end else begin
            model_ptr = (own + 1) % N;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        i_req   = '0;
        i_abort = '0;
        i_x_bn  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", o_grant, 64'd0);
        chk("rst_done", o_done, 64'd0);
        chk("rst_start_stop", {o_gen_start, o_gen_stop}, 64'd0);
        chk("rst_x", o_gen_x_bn, 64'd0);
        chk("rst_busy", o_busy, 64'd0);
        chk("rst_short", o_short, 64'd0);
        rst_n = 1'b1;

        run_txn(4'b0001, 16, 2, 0, 0, 0, 0, 16'h0);
        run_txn(4'b0100, 16, 1, 0, 7, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 16, $urandom_range(0, 3), 1, 0, 0, 0, 16'h0);
        run_txn(4'b0001, 16, 0, 2, 0, 0, 1, 16'hA5C3);
        run_txn(4'b0010, 9, 1, 0, 0, 0, 0, 16'h0);
        run_txn(4'b1000, 16, 0, 0, 0, 0, 0, 16'h0);
        run_txn(4'b0010, 16, 1, 0, 0, 0, 0, 16'h0);
        run_txn(4'b1100, 16, 1, 0, 0, 5, 0, 16'h0);
        run_txn(4'b1100, 16, 0, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 25; i++)
            run_txn(N'($urandom_range(1, 15)), $urandom_range(1, 40), $urandom_range(0, 3),
                    $urandom_range(0, 1), 0, 0, 0, 16'h0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sn_gen_sched.md
SN_GEN_SCHED -- requirements
Module: sn_gen_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one stochastic-number generator (range 2..8).
REQ-002 Parameter STREAM_LEN, default 16, expected number of generator beats (o_isgen-high cycles) per stream.
REQ-003 i_clk_sn_sched  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n_sn_sched  in  1  reset, asynchronous and active-low.
REQ-005 i_req  in  NUM_REQ  per-requester level request; held until matching o_done.
REQ-006 i_x_bn  in  NUM_REQ x 4 x 4  per-requester four 4-bit binary operands.
REQ-007 i_abort  in  NUM_REQ  per-requester abort; functional only with SN_SCHED_ABORT_EN.
REQ-008 o_grant  out  NUM_REQ  one-hot owner of the generator; all-zero when free.
REQ-009 o_done  out  NUM_REQ  one-cycle pulse to the owner on normal stream completion.
REQ-010 o_gen_start  out  1  one-cycle launch pulse to the generator start input.
REQ-011 o_gen_stop  out  1  one-cycle stop pulse to the generator stop input.
REQ-012 o_gen_x_bn  out  4 x 4  operands latched from the granted requester.
REQ-013 i_gen_isgen  in  1  generator busy flag (high during stream beats).
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_short  out  1  sticky error: a stream ended with fewer than STREAM_LEN beats.

Function
REQ-016 States SHALL be IDLE, LAUNCH, WAIT_GEN, RUN, DONE, STOP.
REQ-017 IDLE: if any i_req bit is high, the round-robin arbiter SHALL select the first requesting index at or after rr_ptr (wrapping NUM_REQ-1 -> 0); on that edge o_grant, o_gen_x_bn latch and state -> LAUNCH.
REQ-018 LAUNCH: o_gen_start SHALL be 1 for exactly this one cycle; next state WAIT_GEN.
REQ-019 WAIT_GEN: hold until i_gen_isgen=1, then -> RUN with beat counter = 1; no timeout.
REQ-020 RUN: each cycle with i_gen_isgen=1 SHALL increment the beat counter (saturating at 2*STREAM_LEN); first cycle with i_gen_isgen=0 -> DONE.
REQ-021 On RUN exit, if beat counter < STREAM_LEN, o_short SHALL set and stay set until reset.
REQ-022 DONE: o_done[owner]=1 for one cycle; on exit o_grant clears, rr_ptr = (owner+1) mod NUM_REQ, state -> IDLE.
REQ-023 o_gen_x_bn SHALL remain constant from grant until the next grant regardless of i_x_bn changes.
REQ-024 Requests dropped by a non-owner before grant SHALL be ignored; the owner dropping i_req mid-stream SHALL NOT alter sequencing.
REQ-025 Minimum request-to-request turnaround: one IDLE cycle between DONE and the next LAUNCH.

Reset
REQ-026 While i_rst_n_sn_sched=0: state IDLE, rr_ptr 0, beat counter 0, o_grant 0, o_done 0, o_gen_start 0, o_gen_stop 0, o_gen_x_bn 0, o_busy 0, o_short 0.
REQ-027 Reset asserted mid-stream SHALL abandon the stream without o_done; generator recovery is the generator's own reset.

Configuration
REQ-028 Macro SN_SCHED_ABORT_EN defined: i_abort[owner]=1 in WAIT_GEN or RUN SHALL move to STOP; STOP asserts o_gen_stop one cycle, waits i_gen_isgen=0, then clears o_grant, advances rr_ptr, -> IDLE with no o_done and no o_short update.
REQ-029 Macro undefined: i_abort port present but ignored, o_gen_stop tied 0, STOP unreachable.

Structure
REQ-030 Package sn_sched_pkg SHALL hold the state enum, the 4x4 operand typedef, and default STREAM_LEN/NUM_REQ constants.
REQ-031 Sub-module sn_rr_arbiter SHALL implement the combinational rotate-priority select (inputs req, rr_ptr; outputs one-hot grant, index, any).

Verification
REQ-032 Reset, i_req=0001, generator model isgen high 16 cycles -> o_grant=0001, one o_gen_start pulse, o_done[0] one pulse, o_short=0.
REQ-033 i_req=1111 held, each re-raised after done -> grant order 0,1,2,3,0 with o_gen_x_bn matching each owner.
REQ-034 Owner changes i_x_bn from 16'hA5C3 to 16'h0000 during RUN -> o_gen_x_bn stays 16'hA5C3.
REQ-035 Generator model drops isgen after 9 beats -> o_done pulse still issued, o_short=1 and sticky.
REQ-036 Reset pulsed low in RUN at beat 7 -> all outputs zero immediately, no o_done, next request served from index 0.
REQ-037 With SN_SCHED_ABORT_EN, i_abort[2] at beat 5 -> o_gen_stop one cycle, no o_done[2], grant passes to index 3 next.
